// File: rtl/hazard_scoreboard.sv
// In-flight write tracker beside ID: drives the ID stall and the EXE bypass selects.
// Ports: clk, reset (async, active-low); ID operand/dest info; flush, cnt_clr in;
//        stall, fwd_sel1, fwd_sel2, stall_cnt out.
module hazard_scoreboard #(
    parameter int REG_ADDR_W   = 4,
    parameter int DEPTH        = 2,
    parameter int FWD_EN       = 0,
    parameter int FLUSH_STAGES = 1,
    parameter int CNT_W        = 16,
    localparam int SEL_W       = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_two_src,
    input  logic                  id_wb_en,
    input  logic                  id_mem_r_en,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  flush,
    input  logic                  cnt_clr,
    output logic                  stall,
    output logic [SEL_W-1:0]      fwd_sel1,
    output logic [SEL_W-1:0]      fwd_sel2,
    output logic [CNT_W-1:0]      stall_cnt
);

    typedef struct packed {
        logic                  v;
        logic                  wb;
        logic                  mr;
        logic [REG_ADDR_W-1:0] dest;
    } entry_t;

    entry_t           e [DEPTH];
    logic [DEPTH-1:0] m1;
    logic [DEPTH-1:0] m2;
    logic             hazard;

    // The oldest entry's load flag only matters while it is still in e[0].
    logic unused_mr;
    assign unused_mr = e[DEPTH-1].mr;

    always_comb begin
        m1 = '0;
        m2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            m1[k] = e[k].v & e[k].wb & (e[k].dest == id_src1);
            m2[k] = e[k].v & e[k].wb & (e[k].dest == id_src2);
        end
    end

    // With bypassing only a load still in EXE cannot be forwarded in time.
    always_comb begin
        hazard = 1'b0;
        if (FWD_EN != 0)
            hazard = (m1[0] | (id_two_src & m2[0])) & e[0].mr;
        else
            hazard = (|m1) | (id_two_src & (|m2));
    end

    assign stall = id_valid & ~flush & hazard;

    // Scan oldest to youngest so the youngest writer ends up selected.
    always_comb begin
        fwd_sel1 = '0;
        fwd_sel2 = '0;
        if (FWD_EN != 0 && id_valid) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (m1[k]) fwd_sel1 = SEL_W'(k + 1);
                if (m2[k]) fwd_sel2 = SEL_W'(k + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++)
                e[k] <= '0;
        end else begin
            e[0] <= '{v:    id_valid & ~stall & ~flush,
                      wb:   id_wb_en,
                      mr:   id_mem_r_en,
                      dest: id_dest};
            for (int k = 1; k < DEPTH; k++) begin
                if (flush && k < FLUSH_STAGES)
                    e[k] <= '0;
                else
                    e[k] <= e[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (cnt_clr)
            stall_cnt <= '0;
        else if (stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: two scoreboard configs share one random/directed stimulus stream.
// Expected outputs come from an issue-history model and are checked by a monitor.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_two_src, id_wb_en, id_mem_r_en;
    logic [3:0] id_src1, id_src2, id_dest;
    logic       flush, cnt_clr;

    logic        st0, st1;
    logic [1:0]  a0, b0, a1, b1;
    logic [3:0]  c0;
    logic [15:0] c1;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .REG_ADDR_W(4), .DEPTH(2), .FWD_EN(0), .FLUSH_STAGES(1), .CNT_W(4)
    ) u0 (
        .clk(clk), .reset(rst_n), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
        .flush(flush), .cnt_clr(cnt_clr), .stall(st0),
        .fwd_sel1(a0), .fwd_sel2(b0), .stall_cnt(c0)
    );

    hazard_scoreboard #(
        .REG_ADDR_W(4), .DEPTH(3), .FWD_EN(1), .FLUSH_STAGES(2), .CNT_W(16)
    ) u1 (
        .clk(clk), .reset(rst_n), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
        .flush(flush), .cnt_clr(cnt_clr), .stall(st1),
        .fwd_sel1(a1), .fwd_sel2(b1), .stall_cnt(c1)
    );

    typedef struct {
        int d;
        int cyc;
        int dest;
        bit wb;
        bit mr;
        bit killed;
    } rec_t;

    typedef struct {
        bit st0, st1;
        int a0, b0, c0, a1, b1, c1;
    } exp_t;

    rec_t hist[$];
    exp_t q[$];
    int   cur = 0;
    int   cnt[2];
    int   total = 0;
    int   bad = 0;

    // Age a = cycles since issue; age 1 is the instruction now in EXE.
    function automatic void model(input int d, output bit st,
                                  output int s1, output int s2);
        int dep;
        bit any, lu;
        dep = (d == 0) ? 2 : 3;
        any = 0; lu = 0; s1 = 0; s2 = 0;
        for (int a = dep; a >= 1; a--) begin
            foreach (hist[i]) begin
                if (hist[i].d == d && !hist[i].killed && hist[i].wb
                    && hist[i].cyc == cur - a) begin
                    if (hist[i].dest == int'(id_src1)) begin
                        any = 1; s1 = a;
                        if (a == 1 && hist[i].mr) lu = 1;
                    end
                    if (hist[i].dest == int'(id_src2)) begin
                        s2 = a;
                        if (id_two_src) begin
                            any = 1;
                            if (a == 1 && hist[i].mr) lu = 1;
                        end
                    end
                end
            end
        end
        st = id_valid && !flush && ((d == 1) ? lu : any);
        if (d == 0 || !id_valid) begin
            s1 = 0; s2 = 0;
        end
    endfunction

    task automatic step(bit v, int s1, int s2, bit two, bit wb, bit mr,
                        int dst, bit fl, bit clr, bit rst);
        exp_t x;
        bit   st[2];
        int   ea, eb, fs, mx;
        id_valid = v; id_src1 = 4'(s1); id_src2 = 4'(s2);
        id_two_src = two; id_wb_en = wb; id_mem_r_en = mr;
        id_dest = 4'(dst); flush = fl; cnt_clr = clr; rst_n = rst;
        if (!rst) begin
            hist.delete();
            cnt[0] = 0; cnt[1] = 0;
        end
        model(0, st[0], ea, eb);
        x.st0 = st[0]; x.a0 = ea; x.b0 = eb; x.c0 = cnt[0];
        model(1, st[1], ea, eb);
        x.st1 = st[1]; x.a1 = ea; x.b1 = eb; x.c1 = cnt[1];
        q.push_back(x);
        @(posedge clk);
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                fs = (d == 0) ? 1 : 2;
                mx = (d == 0) ? 15 : 65535;
                if (fl)
                    foreach (hist[i])
                        if (hist[i].d == d && cur - hist[i].cyc <= fs - 1)
                            hist[i].killed = 1;
                if (v && !st[d] && !fl)
                    hist.push_back('{d, cur, dst, wb, mr, 1'b0});
                if (clr) cnt[d] = 0;
                else if (st[d] && cnt[d] < mx) cnt[d]++;
            end
        end
        cur++;
        while (hist.size() > 0 && cur - hist[0].cyc > 5)
            void'(hist.pop_front());
        #1;
    endtask

    task automatic chk(string n, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", n, cur, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (q.size() > 0) begin
            x = q.pop_front();
            chk("u0_stall", int'(st0), int'(x.st0));
            chk("u0_sel1", int'(a0), x.a0);
            chk("u0_sel2", int'(b0), x.b0);
            chk("u0_cnt", int'(c0), x.c0);
            chk("u1_stall", int'(st1), int'(x.st1));
            chk("u1_sel1", int'(a1), x.a1);
            chk("u1_sel2", int'(b1), x.b1);
            chk("u1_cnt", int'(c1), x.c1);
        end
    end

    initial begin
        id_valid = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0;
        id_wb_en = 0; id_mem_r_en = 0; id_dest = 0;
        flush = 0; cnt_clr = 0; rst_n = 0;
        @(posedge clk); #1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // writer r3, then hold a reader of r3
        step(1, 0, 0, 0, 1, 0, 3, 0, 0, 1);
        repeat (3) step(1, 3, 0, 0, 0, 0, 1, 0, 0, 1);
        // src2 matches but is not read
        step(1, 0, 0, 0, 1, 0, 3, 0, 0, 1);
        repeat (3) step(1, 1, 3, 0, 0, 0, 2, 0, 0, 1);
        // ALU r5 then reader, held
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1, 0, 5, 0, 0, 1);
        repeat (3) step(1, 5, 0, 0, 0, 0, 0, 0, 0, 1);
        // load r7 then reader on src2
        step(1, 0, 0, 0, 1, 1, 7, 0, 0, 1);
        repeat (3) step(1, 2, 7, 1, 0, 0, 0, 0, 0, 1);
        // hazard under flush; killed writer of r6
        step(1, 0, 0, 0, 1, 1, 4, 0, 0, 1);
        step(1, 4, 0, 0, 1, 0, 6, 1, 0, 1);
        step(1, 6, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 6, 4, 1, 0, 0, 0, 0, 0, 1);
        // 20 stall cycles on the 4-bit counter
        repeat (10) begin
            step(1, 0, 0, 0, 1, 1, 9, 0, 0, 1);
            repeat (3) step(1, 9, 0, 0, 0, 0, 0, 0, 0, 1);
        end
        step(1, 0, 0, 0, 1, 1, 9, 0, 0, 1);
        step(1, 9, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 9, 0, 0, 0, 0, 0, 0, 0, 1);
        // clear priority over increment
        step(1, 0, 0, 0, 1, 1, 8, 0, 0, 1);
        step(1, 8, 0, 0, 0, 0, 0, 0, 1, 1);
        step(1, 8, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (400) begin
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 3),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 99) != 0);
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
